priority_arbiter: RTL and testbench
===================================

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples needed before a sensor level change is accepted (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 east_sensor  input  1  raw, asynchronous east-approach vehicle sensor, high = vehicle present.
REQ-005 west_sensor  input  1  raw, asynchronous west-approach vehicle sensor, high = vehicle present.
REQ-006 timing_done  input  1  one-cycle pulse from the downstream timing controller marking the end of a light phase.
REQ-007 priority  output  2  registered priority code to the traffic FSM: 00 none, 01 east, 10 west; 11 never driven.
REQ-008 pending  output  2  registered outstanding-request flags, bit0 east, bit1 west.
REQ-009 last_grant  output  1  registered side most recently granted, 0 east, 1 west.

Function
REQ-010 Each sensor SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Each side SHALL hold a debounced level and a debounce counter sized for DEBOUNCE_CYCLES.
REQ-012 Counter clears whenever the synchronized level equals the debounced level.
REQ-013 Counter increments each cycle the synchronized level differs from the debounced level.
REQ-014 Debounced level toggles, and the counter clears, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-015 Any sample matching the debounced level before that count is reached SHALL discard the partial count.
REQ-016 Latency: a raw sensor held high from edge 0 SHALL set the debounced level on edge DEBOUNCE_CYCLES+2 and the pending bit on edge DEBOUNCE_CYCLES+3.
REQ-017 A pending bit SHALL be set one edge after a debounced rising edge on its side; falling edges never set or clear pending.
REQ-018 Arbiter states SHALL be IDLE (priority 00), EAST (01) and WEST (10).
REQ-019 The state SHALL change only on an edge where timing_done is sampled high; at all other times priority holds.
REQ-020 On timing_done with both pending bits set, the arbiter SHALL grant the side opposite last_grant (round robin).
REQ-021 On timing_done with exactly one pending bit set, the arbiter SHALL grant that side regardless of last_grant.
REQ-022 On timing_done with no pending bits set, the arbiter SHALL enter IDLE and leave last_grant unchanged.
REQ-023 On a grant, priority and last_grant SHALL update on the same edge and the granted side's pending bit SHALL clear on that edge.
REQ-024 If a set condition and a grant-clear for the same side occur on one edge, set SHALL win and pending stays 1.
REQ-025 The granted side's sensor remaining high after its grant SHALL NOT re-set pending; only a new debounced rising edge sets it.
REQ-026 timing_done asserted on consecutive cycles SHALL be treated as separate decision events.

Reset
REQ-027 While rst is high on an edge: priority=00, pending=00, last_grant=1 (so east wins the first tie), debounced levels=0, counters=0, synchronizers=0.
REQ-028 Reset asserted mid-operation SHALL discard all pending requests and partial debounce counts within that single edge.
REQ-029 No output SHALL change on the first edge after rst falls except through normal REQ-010..026 behaviour.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset, east_sensor high from edge 0 -> pending=01 at edge 7; then timing_done pulse -> priority=01, pending=00, last_grant=0 on that edge.
REQ-031 Both sensors high together, then three timing_done pulses with re-requests between -> priority 01, then 10, then 01 (strict alternation).
REQ-032 west_sensor glitch high for 3 cycles, then low -> pending stays 00 and debounced level never rises.
REQ-033 Pending bits 00 on timing_done while priority=10 -> priority=00, last_grant stays 1.
REQ-034 East debounced rise on the same edge east is granted -> priority=01 and pending[0] remains 1.
REQ-035 Both pending bits set, rst pulsed for one cycle -> all outputs return to reset values on that edge; priority stays 00 until the next request and timing_done.

Source files
------------

// File: rtl/priority_arbiter.sv
// Two-sensor traffic priority arbiter: synchronizes and debounces the east/west
// vehicle sensors, latches requests, and grants round-robin on each timing_done.

module priority_arbiter_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // rise is a one-cycle pulse on the edge the debounced level goes 0->1
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
                rise  <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module priority_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       east_sensor,
    input  logic       west_sensor,
    input  logic       timing_done,
    output logic [1:0] priority_code,
    output logic [1:0] pending,
    output logic       last_grant
);
    localparam int NUM_LANES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EAST = 2'b01,
        WEST = 2'b10
    } state_t;

    state_t                 state;
    logic [NUM_LANES-1:0]   sensor;
    logic [NUM_LANES-1:0]   deb_rise;
    logic [NUM_LANES-1:0]   grant;

    assign sensor = {west_sensor, east_sensor};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        priority_arbiter_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (sensor[i]),
            .rise (deb_rise[i])
        );
    end

    // On a tie, serve the side that was not granted last
    always_comb begin
        grant = '0;
        if (timing_done) begin
            case (pending)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            last_grant <= 1'b1;
        end else begin
            // A new debounced rise wins over the grant clearing the same side
            pending <= deb_rise | (pending & ~grant);
            if (timing_done) begin
                if (grant[0]) begin
                    state      <= EAST;
                    last_grant <= 1'b0;
                end else if (grant[1]) begin
                    state      <= WEST;
                    last_grant <= 1'b1;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    assign priority_code = state;
endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter with DEBOUNCE_CYCLES=4.

module tb_priority_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       east_sensor = 1'b0;
    logic       west_sensor = 1'b0;
    logic       timing_done = 1'b0;
    logic [1:0] priority_code;
    logic [1:0] pending;
    logic       last_grant;

    int tests = 0;
    int fails = 0;

    priority_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .east_sensor   (east_sensor),
        .west_sensor   (west_sensor),
        .timing_done   (timing_done),
        .priority_code (priority_code),
        .pending       (pending),
        .last_grant    (last_grant)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        east_sensor = 1'b0;
        west_sensor = 1'b0;
        timing_done = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_td();
        timing_done = 1'b1;
        tick(1);
        timing_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        east_sensor = 1'b1;
        west_sensor = 1'b1;
        tick(2);
        tests++; if (priority_code !== 2'b00) begin fails++; $display("FAIL rst_prio got %b want 00", priority_code); end
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL rst_pend got %b want 00", pending); end
        tests++; if (last_grant !== 1'b1) begin fails++; $display("FAIL rst_last got %b want 1", last_grant); end
        east_sensor = 1'b0;
        west_sensor = 1'b0;
        rst = 1'b0;
        tick(1);
        tests++; if ({priority_code, pending, last_grant} !== 5'b00001) begin fails++; $display("FAIL rst_release got %b want 00001", {priority_code, pending, last_grant}); end
    endtask

    task automatic test_single_east();
        do_reset();
        east_sensor = 1'b1;
        tick(6);
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL east_edge6 got %b want 00", pending); end
        tick(1);
        tests++; if (pending !== 2'b01) begin fails++; $display("FAIL east_edge7 got %b want 01", pending); end
        pulse_td();
        tests++; if ({priority_code, pending, last_grant} !== 5'b01000) begin fails++; $display("FAIL east_grant got %b want 01000", {priority_code, pending, last_grant}); end
        tick(10);
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL east_held got %b want 00", pending); end
        east_sensor = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        east_sensor = 1'b1;
        west_sensor = 1'b1;
        tick(7);
        tests++; if (pending !== 2'b11) begin fails++; $display("FAIL rr_both got %b want 11", pending); end
        pulse_td();
        tests++; if ({priority_code, pending, last_grant} !== 5'b01100) begin fails++; $display("FAIL rr_first got %b want 01100", {priority_code, pending, last_grant}); end
        east_sensor = 1'b0;
        tick(8);
        east_sensor = 1'b1;
        tick(7);
        tests++; if (pending !== 2'b11) begin fails++; $display("FAIL rr_rereq_e got %b want 11", pending); end
        pulse_td();
        tests++; if ({priority_code, pending, last_grant} !== 5'b10011) begin fails++; $display("FAIL rr_second got %b want 10011", {priority_code, pending, last_grant}); end
        west_sensor = 1'b0;
        tick(8);
        west_sensor = 1'b1;
        tick(7);
        tests++; if (pending !== 2'b11) begin fails++; $display("FAIL rr_rereq_w got %b want 11", pending); end
        pulse_td();
        tests++; if ({priority_code, pending, last_grant} !== 5'b01100) begin fails++; $display("FAIL rr_third got %b want 01100", {priority_code, pending, last_grant}); end
        east_sensor = 1'b0;
        west_sensor = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset();
        west_sensor = 1'b1;
        tick(3);
        west_sensor = 1'b0;
        tick(12);
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL glitch3 got %b want 00", pending); end
        west_sensor = 1'b1;
        tick(4);
        west_sensor = 1'b0;
        tick(2);
        tests++; if (pending !== 2'b00) begin fails++; $display("FAIL pulse4_edge6 got %b want 00", pending); end
        tick(1);
        tests++; if (pending !== 2'b10) begin fails++; $display("FAIL pulse4_edge7 got %b want 10", pending); end
    endtask

    task automatic test_back_to_back();
        timing_done = 1'b1;
        tick(1);
        tests++; if ({priority_code, pending, last_grant} !== 5'b10001) begin fails++; $display("FAIL b2b_first got %b want 10001", {priority_code, pending, last_grant}); end
        tick(1);
        timing_done = 1'b0;
        tests++; if ({priority_code, pending, last_grant} !== 5'b00001) begin fails++; $display("FAIL b2b_idle got %b want 00001", {priority_code, pending, last_grant}); end
        tick(3);
        tests++; if (priority_code !== 2'b00) begin fails++; $display("FAIL b2b_hold got %b want 00", priority_code); end
    endtask

    task automatic test_same_edge();
        do_reset();
        east_sensor = 1'b1;
        tick(7);
        tests++; if (pending !== 2'b01) begin fails++; $display("FAIL same_setup got %b want 01", pending); end
        east_sensor = 1'b0;
        tick(8);
        east_sensor = 1'b1;
        tick(6);
        pulse_td();
        tests++; if ({priority_code, pending, last_grant} !== 5'b01010) begin fails++; $display("FAIL same_edge got %b want 01010", {priority_code, pending, last_grant}); end
        pulse_td();
        tests++; if ({priority_code, pending, last_grant} !== 5'b01000) begin fails++; $display("FAIL same_regrant got %b want 01000", {priority_code, pending, last_grant}); end
        east_sensor = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        east_sensor = 1'b1;
        west_sensor = 1'b1;
        tick(7);
        tests++; if (pending !== 2'b11) begin fails++; $display("FAIL mid_setup got %b want 11", pending); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++; if ({priority_code, pending, last_grant} !== 5'b00001) begin fails++; $display("FAIL mid_reset got %b want 00001", {priority_code, pending, last_grant}); end
        pulse_td();
        tests++; if ({priority_code, pending, last_grant} !== 5'b00001) begin fails++; $display("FAIL mid_td_idle got %b want 00001", {priority_code, pending, last_grant}); end
        tick(6);
        tests++; if (pending !== 2'b11) begin fails++; $display("FAIL mid_rereq got %b want 11", pending); end
        pulse_td();
        tests++; if ({priority_code, pending, last_grant} !== 5'b01100) begin fails++; $display("FAIL mid_grant got %b want 01100", {priority_code, pending, last_grant}); end
        east_sensor = 1'b0;
        west_sensor = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_east();
        test_round_robin();
        test_glitch();
        test_back_to_back();
        test_same_edge();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
